// File: rtl/counter_pkg.sv
// Shared definitions for the mod_counter slice.
// Contents:
//   state_t      - one-shot FSM state (IDLE / RUN / DONE), 2-bit encoding
//   clamp_val    - limits a requested load value to MODULUS-1
//   terminal_val - terminal count for the current direction
// The helpers work on 32-bit unsigned values. Callers cast the result
// back to the counter width.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Out-of-range load requests saturate to the top of the count range
  // instead of wrapping, so a load can never produce an illegal count.
  function automatic int unsigned clamp_val(input int unsigned value,
                                            input int unsigned modulus);
    return (value >= modulus) ? (modulus - 1) : value;
  endfunction

  // Counting up stops/wraps at MODULUS-1, counting down at 0.
  function automatic int unsigned terminal_val(input logic up,
                                               input int unsigned modulus);
    return up ? (modulus - 1) : 32'd0;
  endfunction

endpackage

// File: rtl/cnt_next.sv
// Combinational next-count logic shared by the free-run and one-shot paths.
// Ports:
//   count       in   current count
//   up          in   direction, 1 = increment
//   nxt         out  count stepped once in the given direction, wrapped
//   at_term     out  count already sits on the terminal value (a step wraps)
//   nxt_is_term out  the stepped value lands on the terminal value
module cnt_next
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term,
  output logic             nxt_is_term
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] term;

  // The wrap is an explicit select on at_term. When MODULUS equals
  // 2**WIDTH the select agrees with plain overflow, so the same logic
  // covers both cases.
  always_comb begin
    term        = WIDTH'(terminal_val(up, MODULUS));
    at_term     = (count == term);
    nxt         = count;
    if (up) begin
      nxt = at_term ? '0 : (count + ONE);
    end else begin
      nxt = at_term ? MAX_VAL : (count - ONE);
    end
    nxt_is_term = (nxt == term);
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter. Features:
//   - up/down counting
//   - synchronous clamped load
//   - enable gating
//   - one-shot mode controlled by a small FSM
// All outputs are registered.
// Optional build macro: COUNTER_CMP_EN adds a registered count==cmp_val
// compare on 'match'. Without the macro, match is tied low and cmp_val
// is ignored.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en, up              count enable, direction (1 = up)
//   oneshot, start      mode select (1 = one-shot), one-shot arm pulse
//   load, load_val      synchronous load strobe and value (clamped)
//   cmp_val             compare value (COUNTER_CMP_EN only)
//   count, tc           current count, terminal-count pulse
//   busy, match         one-shot run in progress, compare hit
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             match
);

  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_val;
  logic             at_term;
  logic             step_hits_term;

  cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_cnt_next (
    .count       (count_q),
    .up          (up),
    .nxt         (step_val),
    .at_term     (at_term),
    .nxt_is_term (step_hits_term)
  );

  // Next-state logic. The priority order is load, then start, then en.
  // Clearing oneshot while in any state drops the FSM to IDLE, and the
  // counter carries on in free-run mode from its current value.
  // start is ignored in free-run mode.
  // busy_d and tc_d are computed for the cycle after the edge, so both
  // outputs line up with the count value they describe.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    busy_d  = busy_q;

    if (load) begin
      count_d = WIDTH'(clamp_val(32'(load_val), MODULUS));
      state_d = IDLE;
      busy_d  = 1'b0;
    end else if (!oneshot) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      if (en) begin
        count_d = step_val;
        tc_d    = at_term;
      end
    end else begin
      case (state_q)
        IDLE, DONE: begin
          busy_d = 1'b0;
          if (start) begin
            count_d = up ? '0 : MAX_VAL;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
        RUN: begin
          busy_d = 1'b1;
          if (en) begin
            // A direction change can leave the count already on the new
            // terminal value. In that case the run finishes without stepping,
            // so the count never wraps in one-shot mode.
            if (at_term) begin
              state_d = DONE;
              tc_d    = 1'b1;
              busy_d  = 1'b0;
            end else begin
              count_d = step_val;
              if (step_hits_term) begin
                state_d = DONE;
                tc_d    = 1'b1;
                busy_d  = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= RESET_CNT;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;

`ifdef COUNTER_CMP_EN
  logic match_q, match_d;

  // The compare uses the next count, so match is high in the same cycle
  // the matching count is visible. It therefore tracks loads and holds.
  assign match_d = (count_d == cmp_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`else
  logic unused_cmp;

  assign unused_cmp = ^cmp_val;
  assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MODULUS=10, RESET_VAL=0).
// Test structure:
//   - hand-written vector table
//   - hand-written multi-cycle sequences
//   - randomized phase checked against a behavioural reference model
// Expected match values follow the COUNTER_CMP_EN setting of the build.
`timescale 1ns/1ps
module tb_mod_counter;

  localparam int WIDTH     = 4;
  localparam int MODULUS   = 10;
  localparam int RESET_VAL = 0;
`ifdef COUNTER_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             en       = 1'b0;
  logic             up       = 1'b1;
  logic             oneshot  = 1'b0;
  logic             start    = 1'b0;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] cmp_val  = '0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             match;

  int error_count = 0;
  int check_count = 0;

  // Reference model state. The model tracks the count as a plain integer
  // plus a flag that is set while a one-shot run is in progress.
  int m_cnt     = RESET_VAL;
  bit m_running = 1'b0;
  bit m_tc      = 1'b0;

  typedef struct {
    int en;
    int up;
    int oneshot;
    int start;
    int load;
    int lv;
    int exp_count;
    int exp_tc;
    int exp_busy;
  } vec_t;

  vec_t vecs[18];

  mod_counter #(
    .WIDTH     (WIDTH),
    .MODULUS   (MODULUS),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .oneshot  (oneshot),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .cmp_val  (cmp_val),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .match    (match)
  );

  always #5 clk = ~clk;

  // Behavioural model of one clock edge, written directly from the rules:
  // load, then one-shot run/arm, then free-run modulo arithmetic.
  task automatic modelStep(input logic s_en, input logic s_up, input logic s_os,
                           input logic s_start, input logic s_load, input int s_lv);
    int target;
    m_tc = 1'b0;
    if (s_load) begin
      m_cnt     = (s_lv >= MODULUS) ? MODULUS - 1 : s_lv;
      m_running = 1'b0;
    end else if (!s_os) begin
      m_running = 1'b0;
      if (s_en) begin
        m_tc  = s_up ? (m_cnt == MODULUS - 1) : (m_cnt == 0);
        m_cnt = s_up ? (m_cnt + 1) % MODULUS : (m_cnt + MODULUS - 1) % MODULUS;
      end
    end else if (m_running) begin
      if (s_en) begin
        target = s_up ? MODULUS - 1 : 0;
        if (m_cnt != target) m_cnt = s_up ? m_cnt + 1 : m_cnt - 1;
        if (m_cnt == target) begin
          m_running = 1'b0;
          m_tc      = 1'b1;
        end
      end
    end else if (s_start) begin
      m_cnt     = s_up ? 0 : MODULUS - 1;
      m_running = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic s_en, input logic s_up, input logic s_os,
                               input logic s_start, input logic s_load,
                               input logic [WIDTH-1:0] s_lv);
    en       = s_en;
    up       = s_up;
    oneshot  = s_os;
    start    = s_start;
    load     = s_load;
    load_val = s_lv;
    @(posedge clk);
    #1;
    modelStep(s_en, s_up, s_os, s_start, s_load, int'(s_lv));
  endtask

  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int e_count, input logic e_tc,
                             input logic e_busy);
    logic e_match;
    e_match = CMP_EN && (e_count == int'(cmp_val));
    checkField({tag, ".count"}, 32'(count), 32'(e_count));
    checkField({tag, ".tc"}, 32'(tc), 32'(e_tc));
    checkField({tag, ".busy"}, 32'(busy), 32'(e_busy));
    checkField({tag, ".match"}, 32'(match), 32'(e_match));
  endtask

  initial begin
    // Hand-derived vectors starting from count 0 after reset (MODULUS=10).
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  9, 1, 0};  // down from 0 wraps to 9
    vecs[1]  = '{0, 0, 0, 0, 0, 0,  9, 0, 0};  // en low: frozen
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  9, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  9, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0,  8, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 1, 12, 9, 0, 0};  // clamped load
    vecs[6]  = '{1, 1, 0, 0, 1, 3,  3, 0, 0};  // load beats en
    vecs[7]  = '{1, 1, 0, 0, 1, 9,  9, 0, 0};  // load onto terminal: no tc
    vecs[8]  = '{1, 1, 0, 0, 0, 0,  0, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
    vecs[10] = '{1, 1, 0, 1, 0, 0,  2, 0, 0};  // start ignored in free-run
    vecs[11] = '{1, 1, 1, 1, 1, 5,  5, 0, 0};  // load beats start
    vecs[12] = '{1, 1, 1, 0, 0, 0,  5, 0, 0};  // one-shot idle holds
    vecs[13] = '{0, 0, 1, 1, 0, 0,  9, 0, 1};  // arm counting down
    vecs[14] = '{1, 0, 1, 0, 0, 0,  8, 0, 1};
    vecs[15] = '{1, 1, 1, 0, 0, 0,  9, 1, 0};  // up re-targets to 9
    vecs[16] = '{1, 1, 1, 0, 0, 0,  9, 0, 0};  // done: holds
    vecs[17] = '{1, 1, 0, 0, 0, 0,  0, 1, 0};  // back to free-run, wraps

    // Reset state
    cmp_val = 4'd9;
    rst_n   = 1'b0;
    #12;
    checkOutput("reset", RESET_VAL, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].en[0], vecs[i].up[0], vecs[i].oneshot[0],
                    vecs[i].start[0], vecs[i].load[0], 4'(vecs[i].lv));
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_count,
                  vecs[i].exp_tc[0], vecs[i].exp_busy[0]);
    end

    // Free-run up from 0: tc only when returning to 0, match once per lap
    cmp_val = 4'd7;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("free%0d", i), (i + 1) % 10, ((i + 1) % 10) == 0, 1'b0);
    end

    // One-shot run up to 9, with a start mid-run that must be ignored
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("os_arm", 0, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, (k == 3), 1'b0, 4'd0);
      checkOutput($sformatf("os_run%0d", k), k, (k == 9), (k < 9));
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("os_hold%0d", k), 9, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("os_rearm", 0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput($sformatf("os_again%0d", k), k, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-run, observed before the next clock edge
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt     = RESET_VAL;
    m_running = 1'b0;
    checkOutput("async_rst", RESET_VAL, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("rst_restart", 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("rst_step", 1, 1'b0, 1'b1);

    // Leave one-shot mid-run: counting continues in free-run
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("os_exit", 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("os_exit2", 3, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic r_en, r_up, r_os, r_start, r_load;
      logic [WIDTH-1:0] r_lv;
      r_en    = ($urandom_range(0, 3) != 0);
      r_up    = ($urandom_range(0, 7) == 0) ? ~up : up;
      r_os    = ($urandom_range(0, 15) == 0) ? ~oneshot : oneshot;
      r_start = ($urandom_range(0, 5) == 0);
      r_load  = ($urandom_range(0, 11) == 0);
      r_lv    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) cmp_val = 4'($urandom_range(0, 9));
      applyStimulus(r_en, r_up, r_os, r_start, r_load, r_lv);
      checkOutput($sformatf("rand%0d", i), m_cnt, m_tc, m_running);
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the team's 2-bit free-running counter.
- Configurable width and modulus; supports up/down counting, synchronous load, enable gating, and a one-shot mode built on a small FSM.
- Registered terminal-count and compare-match outputs drive the comparator datapath and the timing/strobe generation in the same design.

Parameters:
- WIDTH, 8, counter width in bits (>=2)
- MODULUS, 256, count range 0..MODULUS-1; 2<=MODULUS<=2**WIDTH
- RESET_VAL, 0, value of count after reset; must be < MODULUS

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  count enable; no count change when low
- up  in  1  direction, 1 = increment, 0 = decrement
- oneshot  in  1  mode select: 0 = free-run (wrap), 1 = one-shot
- start  in  1  one-shot arm pulse
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded by load (clamped, see Behaviour)
- cmp_val  in  WIDTH  compare value (used only with COUNTER_CMP_EN)
- count  out  WIDTH  current count
- tc  out  1  terminal-count pulse, 1 cycle
- busy  out  1  one-shot run in progress
- match  out  1  count == cmp_val (with COUNTER_CMP_EN)

Behaviour:
- Reset (rst_n low, asynchronous): count=RESET_VAL, tc=0, busy=0, match=0, FSM=IDLE.
- Priority each cycle is load > start > en.
- Load: count<=load_val next cycle, or MODULUS-1 if load_val>=MODULUS. tc is not asserted on load. In one-shot mode, load also returns the FSM to IDLE.
- Terminal value: MODULUS-1 when up=1, 0 when up=0.
- Free-run (oneshot=0), en=1:
  - up: count+1, wrapping MODULUS-1 -> 0.
  - down: count-1, wrapping 0 -> MODULUS-1.
  - tc=1 for exactly the cycle after the wrap edge, i.e. registered and coincident with count showing the wrapped value.
- en=0: count holds, tc=0.
- One-shot FSM, states IDLE, RUN, DONE:
  - IDLE: start=1 -> RUN; count<=0 if up, else MODULUS-1; busy=1 from the next cycle.
  - RUN: counts while en=1. Reaching the terminal value -> DONE, with tc=1 for one cycle and busy=0 in that same cycle. The count holds at the terminal value with no wrap.
  - DONE: holds; start -> RUN (re-arm, count reinitialised); oneshot=0 -> IDLE.
  - start while in RUN is ignored.
  - Changing up mid-RUN re-targets the terminal value immediately.
- oneshot toggled 1->0 mid-RUN: FSM -> IDLE, count continues in free-run from its current value.
- MODULUS=2**WIDTH: wrap arises from natural overflow; no extra compare logic required.
- Latency: all outputs are registered; the count updates 1 cycle after the qualifying input.

Optional Feature:
- COUNTER_CMP_EN defined:
  - Compare logic present; match is registered.
  - match=1 in the cycle where count equals cmp_val, sampled from the same edge. It tracks loads and holds.
- COUNTER_CMP_EN undefined:
  - match tied to 0 and cmp_val unused.
  - No comparator flops synthesised.

Decomposition:
- counter_pkg: FSM state typedef (IDLE/RUN/DONE, 2-bit encoding) and the clamp/terminal-value helper functions.
- One natural sub-module, cnt_next: combinational next-value with wrap and terminal detection, reused by the free-run and RUN paths.
- FSM and registers stay in mod_counter.

Test Plan:
- WIDTH=4, MODULUS=10, up, en=1 from reset: count 0..9, 0; tc=1 only in the cycle count returns to 0; repeats every 10 cycles.
- Down count from 0 with MODULUS=10 -> count 9, tc=1; en held low 3 cycles -> count frozen, tc=0.
- load=1, load_val=12 (MODULUS=10) -> count=9 next cycle, tc=0; load and en together -> load wins.
- oneshot=1, start, up, MODULUS=5 -> busy=1 for count 0..3; at count 4 tc=1, busy=0; count stays 4; second start -> count 0, busy=1.
- rst_n asserted mid-RUN at count 3 -> count=RESET_VAL immediately (asynchronously), busy=0, FSM=IDLE; after release, start restarts from 0.
- COUNTER_CMP_EN, cmp_val=7, free-run MODULUS=10 -> match=1 exactly when count=7 once per 10 cycles; without the macro, match=0 always.
